poly_solver: RTL and testbench

- Parametrised successor to expression_solver.
- Evaluates an unsigned polynomial P(x) = c[deg]*x^deg + ... + c[1]*x + c[0] by Horner's method, one multiply-add step per clock.
- The degree is selectable at run time, up to MAX_DEG.
- Reports the result with zero and overflow flags, a one-cycle completed pulse and a busy flag. Sits where expression_solver sits, as a multi-cycle arithmetic unit with start/completed handshake.

---
 rtl/poly_solver_pkg.sv | 18 +
 rtl/poly_solver_horner_step.sv | 22 ++
 rtl/poly_solver.sv | 104 ++++++++++
 tb/tb_poly_solver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/poly_solver_pkg.sv
// rtl/poly_solver_pkg.sv - shared types, default widths and helpers for poly_solver
package poly_solver_pkg;

  localparam int DEFAULT_DATA_W  = 16;
  localparam int DEFAULT_X_W     = 8;
  localparam int DEFAULT_MAX_DEG = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int deg_width(input int max_deg);
    return (max_deg < 1) ? 1 : $clog2(max_deg + 1);
  endfunction

endpackage

// File: rtl/poly_solver_horner_step.sv
// rtl/poly_solver_horner_step.sv - one combinational Horner multiply-add step
module horner_step #(
  parameter int DATA_W = 16,
  parameter int X_W    = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [X_W-1:0]    x,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] next_acc,
  output logic              step_ovf
);

  logic [DATA_W+X_W-1:0] prod;
  logic [DATA_W:0]       sum;

  assign prod     = {{X_W{1'b0}}, acc} * {{DATA_W{1'b0}}, x};
  assign sum      = {1'b0, prod[DATA_W-1:0]} + {1'b0, c};
  assign next_acc = sum[DATA_W-1:0];
  // Either a non-zero high product half or the add carry loses information.
  assign step_ovf = (|prod[DATA_W+X_W-1:DATA_W]) | sum[DATA_W];

endmodule

// File: rtl/poly_solver.sv
// rtl/poly_solver.sv - run-time degree polynomial evaluator, one Horner step per clock
module poly_solver
  import poly_solver_pkg::*;
#(
  parameter int  DATA_W  = DEFAULT_DATA_W,
  parameter int  X_W     = DEFAULT_X_W,
  parameter int  MAX_DEG = DEFAULT_MAX_DEG,
  localparam int DEG_W   = deg_width(MAX_DEG)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DEG_W-1:0]            deg,
  input  logic [X_W-1:0]              x,
  input  logic [(MAX_DEG+1)*DATA_W-1:0] coeffs,
  output logic [DATA_W-1:0]           result,
  output logic                        zero,
  output logic                        overflow,
  output logic                        completed,
  output logic                        busy
);

  state_t state, state_next;

  logic [X_W-1:0]    x_lat;
  logic [DATA_W-1:0] c_lat [MAX_DEG+1];
  logic [DATA_W-1:0] acc;
  logic [DEG_W-1:0]  cnt;
  logic [DEG_W-1:0]  deg_eff;
  logic              ov;
  logic [DATA_W-1:0] step_acc;
  logic              step_ovf;

  always_comb begin
    deg_eff = deg;
    if (int'(deg) > MAX_DEG) deg_eff = DEG_W'(MAX_DEG);
  end

  horner_step #(
    .DATA_W(DATA_W),
    .X_W   (X_W)
  ) u_step (
    .acc     (acc),
    .x       (x_lat),
    .c       (c_lat[cnt - 1'b1]),
    .next_acc(step_acc),
    .step_ovf(step_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (deg_eff == '0) ? DONE : EVAL;
      EVAL:    if (cnt == DEG_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_lat     <= '0;
      acc       <= '0;
      cnt       <= '0;
      ov        <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      completed <= 1'b0;
      for (int k = 0; k <= MAX_DEG; k++) c_lat[k] <= '0;
    end else begin
      completed <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_lat <= x;
          for (int k = 0; k <= MAX_DEG; k++) c_lat[k] <= coeffs[k*DATA_W +: DATA_W];
          acc <= coeffs[deg_eff*DATA_W +: DATA_W];
          cnt <= deg_eff;
          ov  <= 1'b0;
        end
        EVAL: begin
          acc <= step_acc;
          ov  <= ov | step_ovf;
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          result    <= acc;
          zero      <= (acc == '0);
          overflow  <= ov;
          completed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_solver.sv
// tb/tb_poly_solver.sv - randomized self-checking bench for poly_solver against an arithmetic model
module tb_poly_solver;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  deg;
  logic [7:0]  x;
  logic [63:0] coeffs;
  logic [15:0] result;
  logic        zero;
  logic        overflow;
  logic        completed;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  poly_solver dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .deg      (deg),
    .x        (x),
    .coeffs   (coeffs),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .completed(completed),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Plain polynomial arithmetic: any step whose exact value reaches 2^16 overflowed.
  function automatic void model(input int d, input logic [7:0] xv, input logic [63:0] cv,
                                output logic [15:0] r, output logic o);
    longint unsigned a, full;
    a = longint'(cv[d*16 +: 16]);
    o = 1'b0;
    for (int k = d - 1; k >= 0; k--) begin
      full = a * longint'(xv) + longint'(cv[k*16 +: 16]);
      if (full >= 64'd65536) o = 1'b1;
      a = full % 64'd65536;
    end
    r = a[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_eval(input int d, input logic [7:0] xv, input logic [63:0] cv,
                          input bit hold, input int disturb_at);
    logic [15:0] exp_r;
    logic        exp_o;
    model(d, xv, cv, exp_r, exp_o);
    deg    = 2'(d);
    x      = xv;
    coeffs = cv;
    start  = 1'b1;
    step();
    if (!hold) start = 1'b0;
    for (int i = 0; i <= d; i++) begin
      check("busy_during_eval", busy, 1);
      check("completed_early", completed, 0);
      if (i == disturb_at) begin
        start  = 1'b1;
        x      = 8'($urandom);
        coeffs = {$urandom, $urandom};
        deg    = 2'($urandom);
      end else if (!hold) begin
        start = 1'b0;
      end
      step();
    end
    if (!hold) start = 1'b0;
    check("completed_pulse", completed, 1);
    check("busy_after_done", busy, 0);
    check("result", result, exp_r);
    check("zero", zero, exp_r == 16'd0);
    check("overflow", overflow, exp_o);
    if (!hold) begin
      step();
      check("completed_drops", completed, 0);
      check("busy_stays_low", busy, 0);
      check("result_holds", result, exp_r);
      check("overflow_holds", overflow, exp_o);
    end
  endtask

  initial begin
    logic [63:0] cv;
    int          d;
    rst    = 1'b1;
    start  = 1'b0;
    deg    = '0;
    x      = '0;
    coeffs = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_result", result, 0);
    check("reset_zero", zero, 0);
    check("reset_overflow", overflow, 0);
    check("reset_completed", completed, 0);
    check("reset_busy", busy, 0);

    run_eval(2, 8'd15, {16'd0, 16'd96, 16'd3, 16'd1}, 1'b0, -1);
    run_eval(0, 8'd77, {16'd5, 16'd6, 16'd7, 16'd0}, 1'b0, -1);
    run_eval(2, 8'd16, {16'd0, 16'h1000, 16'd0, 16'd0}, 1'b0, -1);
    run_eval(1, 8'd1, {16'd0, 16'd0, 16'hFFFF, 16'd1}, 1'b0, -1);
    run_eval(2, 8'd15, {16'd0, 16'd96, 16'd3, 16'd1}, 1'b0, 1);

    deg    = 2'd2;
    x      = 8'd15;
    coeffs = {16'd0, 16'd96, 16'd3, 16'd1};
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_result", result, 0);
    check("abort_zero", zero, 0);
    check("abort_overflow", overflow, 0);
    check("abort_completed", completed, 0);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_no_pulse", completed, 0);
    end
    run_eval(2, 8'd15, {16'd0, 16'd96, 16'd3, 16'd1}, 1'b0, -1);

    run_eval(3, 8'd2, {16'd1, 16'd1, 16'd1, 16'd1}, 1'b1, -1);
    run_eval(3, 8'd2, {16'd1, 16'd1, 16'd1, 16'd1}, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      d = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++)
        cv[k*16 +: 16] = 16'($urandom_range(0, ($urandom % 2 == 0) ? 255 : 65535));
      run_eval(d, 8'($urandom_range(0, (n % 3 == 0) ? 255 : 20)), cv, 1'b0,
               (d > 0 && n % 4 == 0) ? int'($urandom_range(1, d)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
